clk_div_ctrl: RTL and testbench

Controller that sequences and configures the clk_32f-derived clock tree for the serial datapath. Runs on clk_32f, owns the divider counter, and drives clk_4f/clk_2f/clk_f plus single-cycle strobes. It brings outputs up through a warm-up period, reports lock, and applies divide-ratio changes only at a common-phase boundary so no downstream domain sees a runt pulse. Instanced beside the 4f/2f/f consumers in place of a free-running generator.

---
 rtl/clk_ctrl_pkg.sv | 24 ++
 rtl/clk_div_counter.sv | 37 +++
 rtl/clk_div_ctrl.sv | 101 ++++++++++
 tb/tb_clk_div_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_ctrl_pkg.sv
// clk_ctrl_pkg: state encoding, ratio codes and counter wrap helper shared by clk_div_ctrl and its counter.
package clk_ctrl_pkg;

   localparam int CNT_W = 5;

   typedef enum logic [1:0] {ST_IDLE, ST_WARMUP, ST_RUN, ST_DRAIN} state_e;

   typedef enum logic [1:0] {
      DIV_8   = 2'b00,
      DIV_4   = 2'b01,
      DIV_2   = 2'b10,
      DIV_RSV = 2'b11
   } div_e;

   function automatic div_e map_div(input logic [1:0] code);
      return (code == DIV_RSV) ? DIV_8 : div_e'(code);
   endfunction

   // Last count of one clk_f period: 31, 15 or 7 for codes 00, 01, 10.
   function automatic logic [CNT_W-1:0] wrap_val(input div_e d);
      return {CNT_W{1'b1}} >> d;
   endfunction

endpackage

// File: rtl/clk_div_counter.sv
// clk_div_counter: wrapping phase counter with load-zero, plus registered 4f/2f/f clocks and rise strobes.
module clk_div_counter
   import clk_ctrl_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       clr_i,
   input  logic       out_en_i,
   input  div_e       div_i,
   output logic       wrap_o,
   output logic [2:0] clk_o,
   output logic [2:0] stb_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       clk_q, clk_d, stb_q;

   assign wrap_o = cnt_q == wrap_val(div_i);
   assign cnt_d  = (clr_i || wrap_o) ? '0 : cnt_q + 1'b1;
   // Shifting left by d lands cnt[2-d], cnt[3-d], cnt[4-d] on bits 2..4.
   assign clk_d  = out_en_i ? 3'((cnt_q << div_i) >> 2) : 3'b000;
   assign clk_o  = clk_q;
   assign stb_o  = stb_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         clk_q <= '0;
         stb_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         clk_q <= clk_d;
         stb_q <= clk_d & ~clk_q;
      end
   end

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: sequences the clk_32f-derived 4f/2f/f clocks and applies ratio changes at the wrap boundary.
// Define CLK_DIV_CTRL_WARMUP_EN to insert a WARMUP_CYC-cycle warm-up between IDLE and RUN.
module clk_div_ctrl
   import clk_ctrl_pkg::*;
`ifdef CLK_DIV_CTRL_WARMUP_EN
#(
   parameter int WARMUP_CYC = 8
)
`endif
(
   input  logic       clk_32f_i,
   input  logic       reset_ni,
   input  logic       enable_i,
   input  logic       cfg_req_i,
   input  logic [1:0] cfg_div_i,
   output logic       cfg_ack_o,
   output logic       clk_4f_o,
   output logic       clk_2f_o,
   output logic       clk_f_o,
   output logic       stb_4f_o,
   output logic       stb_2f_o,
   output logic       stb_f_o,
   output logic       locked_o
);

`ifdef CLK_DIV_CTRL_WARMUP_EN
   localparam state_e ST_ON = ST_WARMUP;
   logic [7:0] warm_q;
`else
   localparam state_e ST_ON = ST_RUN;
`endif

   state_e     state_q, state_d;
   div_e       d_q, d_d, pend_q, pend_d;
   logic       pend_v_q, pend_v_d, ack_q, lock_q;
   logic       wrap, apply, running, run_next;
   logic [2:0] clk_v, stb_v;

   assign running  = state_q inside {ST_RUN, ST_DRAIN};
   assign run_next = state_d inside {ST_RUN, ST_DRAIN};
   // While stopped the counter sits at 0, so a pending ratio can land immediately.
   assign apply    = pend_v_q && (!running || wrap);
   assign d_d      = apply ? pend_q : d_q;
   assign pend_v_d = cfg_req_i || (pend_v_q && !apply);
   assign pend_d   = cfg_req_i ? map_div(cfg_div_i) : pend_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   state_d = enable_i ? ST_ON : ST_IDLE;
`ifdef CLK_DIV_CTRL_WARMUP_EN
         ST_WARMUP: state_d = !enable_i ? ST_IDLE :
                              (warm_q == 8'(WARMUP_CYC - 1)) ? ST_RUN : ST_WARMUP;
`endif
         ST_RUN:    state_d = enable_i ? ST_RUN : ST_DRAIN;
         ST_DRAIN:  state_d = enable_i ? ST_RUN : wrap ? ST_IDLE : ST_DRAIN;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_32f_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q  <= ST_IDLE;
         d_q      <= DIV_8;
         pend_q   <= DIV_8;
         pend_v_q <= 1'b0;
         ack_q    <= 1'b0;
         lock_q   <= 1'b0;
`ifdef CLK_DIV_CTRL_WARMUP_EN
         warm_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         d_q      <= d_d;
         pend_q   <= pend_d;
         pend_v_q <= pend_v_d;
         ack_q    <= apply;
         lock_q   <= run_next;
`ifdef CLK_DIV_CTRL_WARMUP_EN
         warm_q   <= (state_q == ST_WARMUP) ? warm_q + 8'd1 : 8'd0;
`endif
      end
   end

   clk_div_counter u_cnt (
      .clk_i    (clk_32f_i),
      .rst_ni   (reset_ni),
      .clr_i    (!running),
      .out_en_i (run_next),
      .div_i    (d_q),
      .wrap_o   (wrap),
      .clk_o    (clk_v),
      .stb_o    (stb_v)
   );

   assign {clk_f_o, clk_2f_o, clk_4f_o} = clk_v;
   assign {stb_f_o, stb_2f_o, stb_4f_o} = stb_v;
   assign cfg_ack_o = ack_q;
   assign locked_o  = lock_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed and randomized checks of clk_div_ctrl against a cycle model built from the ratio rules.
module tb_clk_div_ctrl;

`ifdef CLK_DIV_CTRL_WARMUP_EN
   localparam int WARM = 8;
`else
   localparam int WARM = 0;
`endif

   logic       clk = 1'b0, reset_n = 1'b0, en = 1'b0, req = 1'b0;
   logic [1:0] div = 2'b00;
   logic       cfg_ack, clk_4f, clk_2f, clk_f, stb_4f, stb_2f, stb_f, locked;
   logic [7:0] outs;
   logic [2:0] stb_v;

   int n_vec = 0, n_err = 0, cyc = 0;
   int ms, mc, md, mpv, mpval, mw;
   logic [2:0] e_clk, e_stb;
   logic e_lock, e_ack;

   always #5 clk = ~clk;

   clk_div_ctrl dut (
      .clk_32f_i (clk),
      .reset_ni  (reset_n),
      .enable_i  (en),
      .cfg_req_i (req),
      .cfg_div_i (div),
      .cfg_ack_o (cfg_ack),
      .clk_4f_o  (clk_4f),
      .clk_2f_o  (clk_2f),
      .clk_f_o   (clk_f),
      .stb_4f_o  (stb_4f),
      .stb_2f_o  (stb_2f),
      .stb_f_o   (stb_f),
      .locked_o  (locked)
   );

   assign outs  = {clk_f, clk_2f, clk_4f, stb_f, stb_2f, stb_4f, locked, cfg_ack};
   assign stb_v = {stb_f, stb_2f, stb_4f};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      ms = 0; mc = 0; md = 0; mpv = 0; mpval = 0; mw = 0;
      e_clk = '0; e_stb = '0; e_lock = 1'b0; e_ack = 1'b0;
   endtask

   // States 0 idle, 1 warmup, 2 run, 3 drain; clock k runs with half-period (4<<k)>>d counts.
   task automatic model_tick();
      int ns, per;
      bit run, wrap, app;
      logic [2:0] nc;
      run  = ms >= 2;
      per  = 32 >> md;
      wrap = run && (mc == per - 1);
      app  = (mpv != 0) && (!run || wrap);
      case (ms)
         0:       ns = en ? ((WARM > 0) ? 1 : 2) : 0;
         1:       ns = !en ? 0 : ((mw == WARM - 1) ? 2 : 1);
         2:       ns = en ? 2 : 3;
         default: ns = en ? 2 : (wrap ? 0 : 3);
      endcase
      for (int k = 0; k < 3; k++)
         nc[k] = (ns >= 2) && (((mc / ((4 << k) >> md)) % 2) == 1);
      e_stb  = nc & ~e_clk;
      e_clk  = nc;
      mw     = (ms == 1) ? mw + 1 : 0;
      mc     = (run && !wrap) ? mc + 1 : 0;
      e_ack  = app;
      if (app) md = mpval;
      if (req) begin
         mpv = 1;
         mpval = (div == 2'b11) ? 0 : int'(div);
      end else if (app) mpv = 0;
      e_lock = ns >= 2;
      ms     = ns;
   endtask

   task automatic step();
      @(posedge clk);
      model_tick();
      cyc++;
      #1;
      chk("outs", 32'(outs), 32'({e_clk, e_stb, e_lock, e_ack}));
   endtask

   task automatic pulse(input logic [1:0] code);
      req = 1'b1;
      div = code;
      step();
      req = 1'b0;
   endtask

   task automatic wait_cnt(input int c);
      int n = 0;
      while (!(ms >= 2 && mc == c) && n < 200) begin
         step();
         n++;
      end
      chk("wait_cnt", 32'(n < 200), 32'd1);
   endtask

   task automatic measure(input string tag, input int n, input int k, input int per);
      int last = -1;
      repeat (n) begin
         step();
         if (stb_v[k]) begin
            if (last >= 0) chk(tag, 32'(cyc - last), 32'(per));
            last = cyc;
         end
      end
      chk({tag, "_seen"}, 32'(last >= 0), 32'd1);
   endtask

   task automatic lock_latency(input string tag);
      int n = 0;
      do begin
         step();
         n++;
      end while (!locked && n < 300);
      chk(tag, 32'(n), 32'(WARM + 1));
   endtask

   task automatic count_acks(input string tag, input int n, input int exp);
      int a = 0;
      repeat (n) begin
         step();
         if (cfg_ack) a++;
      end
      chk(tag, 32'(a), 32'(exp));
   endtask

   initial begin
      int n;
      model_reset();
      #3;
      chk("reset_outs", 32'(outs), 32'd0);
      #9 reset_n = 1'b1;
      repeat (3) step();

      en = 1'b1;
      lock_latency("lock_lat");
      measure("per_f_d0", 100, 2, 32);
      measure("per_4f_d0", 40, 0, 8);

      wait_cnt(5);
      pulse(2'b10);
      n = 1;
      while (!cfg_ack && n < 100) begin
         step();
         n++;
      end
      chk("cfg_lat", 32'(n), 32'd27);
      measure("per_4f_d2", 20, 0, 2);

      wait_cnt(2);
      pulse(2'b01);
      step();
      pulse(2'b11);
      count_acks("dbl_ack_a", 40, 1);
      measure("per_f_rsv", 100, 2, 32);

      wait_cnt($urandom_range(3, 20));
      pulse(2'b01);
      repeat ($urandom_range(0, 5)) step();
      pulse(2'b10);
      count_acks("dbl_ack_b", 40, 1);
      measure("per_4f_dbl", 20, 0, 2);

      pulse(2'b00);
      repeat (20) step();
      wait_cnt(10);
      en = 1'b0;
      n = 0;
      do begin
         step();
         n++;
      end while (locked && n < 100);
      chk("drain_len", 32'(n), 32'd22);
      chk("idle_outs", 32'(outs), 32'd0);

      en = 1'b1;
      lock_latency("relock_lat");
      wait_cnt($urandom_range(5, 25));
      en = 1'b0;
      repeat ($urandom_range(1, 4)) step();
      en = 1'b1;
      measure("per_f_resume", 80, 2, 32);

      wait_cnt(12);
      pulse(2'b10);
      wait_cnt(17);
      #1 reset_n = 1'b0;
      #1 chk("async_reset", 32'(outs), 32'd0);
      model_reset();
      #2 reset_n = 1'b1;
      lock_latency("post_reset_lock");
      measure("per_f_post_rst", 100, 2, 32);
      measure("per_4f_post_rst", 40, 0, 8);

      repeat (400) begin
         req = ($urandom_range(0, 15) == 0);
         div = 2'($urandom_range(0, 3));
         step();
      end
      req = 1'b0;
      repeat (40) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

endmodule
